lift53_line: RTL and testbench

Parametrised 1-D forward LeGall 5/3 integer lifting wavelet for one image line, successor to the fixed 8-bit even/odd squash stage in the image-compression path. Consumes unsigned pixels on a valid/ready stream, applies symmetric boundary extension at both line ends, and emits one (low, high) coefficient pair per two input pixels on a valid/ready stream. Sits between the pixel source (ROM or line buffer) and the quantiser / next decomposition level.

---
 rtl/lift53_line_if.sv | 42 ++++
 rtl/lift53_line.sv | 133 +++++++++++++
 tb/tb_lift53_line.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lift53_line_if.sv
`default_nettype none
// ============================================================================
//  Interface : lift53_line_if
//  Brief     : Pixel-in / coefficient-pair-out valid/ready streams for
//              lift53_line. The optional bypass control exists only when
//              LIFT53_BYPASS_EN is defined.
//  Revision  : 1.0
// ============================================================================
interface lift53_line_if #(
  parameter int DATA_W = 8
);
  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_W-1:0]        in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W+1:0] out_L;
  logic signed [DATA_W+1:0] out_H;
  logic                     out_last;
`ifdef LIFT53_BYPASS_EN
  logic                     bypass;

  modport master (
    output in_valid, in_data, out_ready, bypass,
    input  in_ready, out_valid, out_L, out_H, out_last
  );
  modport slave (
    input  in_valid, in_data, out_ready, bypass,
    output in_ready, out_valid, out_L, out_H, out_last
  );
`else
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_L, out_H, out_last
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_L, out_H, out_last
  );
`endif
endinterface
`default_nettype wire

// File: rtl/lift53_line.sv
`default_nettype none
// ============================================================================
//  Module   : lift53_line
//  Brief    : Forward LeGall 5/3 integer lifting over one image line with
//             symmetric extension at both ends; one (low, high) pair per two
//             input pixels on a valid/ready stream.
//  Config   : LIFT53_BYPASS_EN - adds a per-line bypass input that passes the
//             raw even/odd pixels through as the pair instead of transforming.
//  Revision : 1.0
// ============================================================================
module lift53_line #(
  parameter int DATA_W   = 8,
  parameter int LINE_LEN = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  lift53_line_if.slave bus
);

  localparam int SW    = DATA_W + 2;
  localparam int IDX_W = $clog2(LINE_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_LEN - 1);

  // line position and lifting history
  logic [IDX_W-1:0]     idx;
  logic [DATA_W-1:0]    even_q;
  logic [DATA_W-1:0]    odd_q;
  logic signed [SW-1:0] dprev_q;
  logic                 first_q;

  logic                 accept;
  logic                 is_last;
  logic                 xf_load;
  logic                 xf_commit;
  logic                 pair_load;
  logic signed [SW-1:0] e0, e2, od, avg, d, dleft, s;
  logic signed [SW:0]   upd_sum, upd_q4;
  logic signed [SW-1:0] pair_l, pair_h;

  assign accept       = bus.in_valid && bus.in_ready;
  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign is_last      = (idx == LAST_IDX);

  // Predict/update datapath. On the final odd pixel the right neighbour
  // x[LINE_LEN] mirrors to x[LINE_LEN-2], which is still held in even_q.
  always_comb begin
    e0 = {2'b00, even_q};
    if (is_last) begin
      od = {2'b00, bus.in_data};
      e2 = e0;
    end else begin
      od = {2'b00, odd_q};
      e2 = {2'b00, bus.in_data};
    end
    avg   = (e0 + e2) >>> 1;
    d     = od - avg;
    dleft = first_q ? d : dprev_q;
    // d[n-1] + d[n] + 2 can reach 2^(DATA_W+1), one past the signed range of
    // SW bits, so the update sum gets one guard bit; the quarter fits again.
    upd_sum = {dleft[SW-1], dleft} + {d[SW-1], d} + (SW+1)'(2);
    upd_q4  = upd_sum >>> 2;
    s       = e0 + $signed(upd_q4[SW-1:0]);
  end

  // transformed pairs: every even pixel after x[0], plus the final odd pixel
  assign xf_load = accept && (is_last || (!idx[0] && (idx != '0)));

`ifdef LIFT53_BYPASS_EN
  logic byp_line;
  assign xf_commit = xf_load && !byp_line;
  assign pair_load = byp_line ? (accept && idx[0]) : xf_load;
  assign pair_l    = byp_line ? {2'b00, even_q} : s;
  assign pair_h    = byp_line ? {2'b00, bus.in_data} : d;

  // bypass mode is latched with x[0] and held for the whole line
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byp_line <= 1'b0;
    end else if (accept && (idx == '0)) begin
      byp_line <= bus.bypass;
    end
  end
`else
  assign xf_commit = xf_load;
  assign pair_load = xf_load;
  assign pair_l    = s;
  assign pair_h    = d;
`endif

  // index counter and pixel/detail history, advanced on every acceptance
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx     <= '0;
      even_q  <= '0;
      odd_q   <= '0;
      dprev_q <= '0;
      first_q <= 1'b0;
    end else if (accept) begin
      idx <= is_last ? '0 : idx + 1'b1;
      if (!idx[0]) begin
        even_q <= bus.in_data;
      end else begin
        odd_q <= bus.in_data;
      end
      if (idx == '0) begin
        first_q <= 1'b1;
      end
      if (xf_commit) begin
        dprev_q <= d;
        first_q <= 1'b0;
      end
    end
  end

  // single-entry output register; a new load wins over a drain
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_L     <= '0;
      bus.out_H     <= '0;
      bus.out_last  <= 1'b0;
    end else if (pair_load) begin
      bus.out_valid <= 1'b1;
      bus.out_L     <= pair_l;
      bus.out_H     <= pair_h;
      bus.out_last  <= is_last;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lift53_line.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lift53_line
//  Brief    : Self-checking bench for lift53_line. Two instances (LINE_LEN 4
//             and 16) are driven from pixel queues; collected pairs are
//             compared against a line-level 5/3 reference model.
//  Config   : LIFT53_BYPASS_EN enables the bypass scenario.
//  Revision : 1.0
// ============================================================================
module tb_lift53_line;

  typedef struct {
    int L;
    int H;
    bit last;
    int cyc;
  } pair_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  int    px[$];
  int    inq4[$], inq16[$];
  bit    bypq4[$], bypq16[$];
  pair_t exp4[$], exp16[$], obs4[$], obs16[$];
  int    acc4[$], acc16[$];
  int    rdy_pct4 = 100, rdy_pct16 = 100;
  int    viol4 = 0, viol16 = 0;

  lift53_line_if #(.DATA_W(8)) bif4 ();
  lift53_line_if #(.DATA_W(8)) bif16 ();

  lift53_line #(.DATA_W(8), .LINE_LEN(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bif4)
  );
  lift53_line #(.DATA_W(8), .LINE_LEN(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .bus(bif16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // stream driver / collector for the LINE_LEN=4 instance
  always @(negedge clk) begin
    bif4.out_ready = ($urandom_range(99) < rdy_pct4);
    if (inq4.size() > 0) begin
      bif4.in_valid = 1'b1;
      bif4.in_data  = 8'(inq4[0]);
`ifdef LIFT53_BYPASS_EN
      bif4.bypass   = bypq4[0];
`endif
    end else begin
      bif4.in_valid = 1'b0;
      bif4.in_data  = 8'($urandom);
`ifdef LIFT53_BYPASS_EN
      bif4.bypass   = 1'b0;
`endif
    end
    #1;
    if (bif4.in_valid && bif4.in_ready) begin
      void'(inq4.pop_front());
      void'(bypq4.pop_front());
      acc4.push_back(cyc);
    end
    if (bif4.out_valid && bif4.out_ready)
      obs4.push_back('{int'(bif4.out_L), int'(bif4.out_H), bif4.out_last, cyc});
    if (!bif4.in_ready && !(bif4.out_valid && !bif4.out_ready)) viol4++;
  end

  // stream driver / collector for the LINE_LEN=16 instance
  always @(negedge clk) begin
    bif16.out_ready = ($urandom_range(99) < rdy_pct16);
    if (inq16.size() > 0) begin
      bif16.in_valid = 1'b1;
      bif16.in_data  = 8'(inq16[0]);
`ifdef LIFT53_BYPASS_EN
      bif16.bypass   = bypq16[0];
`endif
    end else begin
      bif16.in_valid = 1'b0;
      bif16.in_data  = 8'($urandom);
`ifdef LIFT53_BYPASS_EN
      bif16.bypass   = 1'b0;
`endif
    end
    #1;
    if (bif16.in_valid && bif16.in_ready) begin
      void'(inq16.pop_front());
      void'(bypq16.pop_front());
      acc16.push_back(cyc);
    end
    if (bif16.out_valid && bif16.out_ready)
      obs16.push_back('{int'(bif16.out_L), int'(bif16.out_H), bif16.out_last, cyc});
    if (!bif16.in_ready && !(bif16.out_valid && !bif16.out_ready)) viol16++;
  end

  // Reference model: whole-line 5/3 lifting from the textbook formulas,
  // with mirrored x[LINE_LEN] and d[-1]. Queues the pixels for driving.
  task automatic push_line(input bit sel16, input bit byp);
    int    len, np, xr, dl;
    int    d[$];
    pair_t p;
    len = px.size();
    np  = len / 2;
    for (int n = 0; n < np; n++) begin
      xr = (2*n + 2 < len) ? px[2*n + 2] : px[len - 2];
      d.push_back(px[2*n + 1] - ((px[2*n] + xr) >>> 1));
    end
    for (int n = 0; n < np; n++) begin
      dl = (n == 0) ? d[0] : d[n - 1];
      if (byp) begin
        p.L = px[2*n];
        p.H = px[2*n + 1];
      end else begin
        p.L = px[2*n] + ((dl + d[n] + 2) >>> 2);
        p.H = d[n];
      end
      p.last = (n == np - 1);
      p.cyc  = 0;
      if (sel16) exp16.push_back(p);
      else       exp4.push_back(p);
    end
    foreach (px[i]) begin
      if (sel16) begin inq16.push_back(px[i]); bypq16.push_back(byp); end
      else       begin inq4.push_back(px[i]);  bypq4.push_back(byp);  end
    end
  endtask

  // waits (bounded) until all queued pixels are taken and all pairs seen
  task automatic wait_drain(input bit sel16, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      #2;
      if (sel16 ? (inq16.size() == 0 && obs16.size() >= exp16.size())
                : (inq4.size() == 0 && obs4.size() >= exp4.size())) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    checks++; if (bif4.out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got %b exp 0", bif4.out_valid); end
    checks++; if (bif4.out_L !== 10'sd0) begin failures++; $display("FAIL rst_L got %0d exp 0", bif4.out_L); end
    checks++; if (bif4.out_H !== 10'sd0) begin failures++; $display("FAIL rst_H got %0d exp 0", bif4.out_H); end
    checks++; if (bif4.out_last !== 1'b0) begin failures++; $display("FAIL rst_last got %b exp 0", bif4.out_last); end
    checks++; if (bif4.in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got %b exp 1", bif4.in_ready); end
    checks++; if (bif16.out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid16 got %b exp 0", bif16.out_valid); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit ok;
    int el[4] = '{26, 57, 0, 0};
    int eh[4] = '{8, 20, 0, 0};
    rdy_pct4 = 100;
    acc4.delete();
    px = '{22, 44, 50, 70};
    push_line(1'b0, 1'b0);
    wait_drain(1'b0, ok);
    checks++; if (!ok || obs4.size() != 2) begin failures++; $display("FAIL basic_count got %0d exp 2", obs4.size()); end
    for (int i = 0; i < 2 && i < obs4.size(); i++) begin
      checks++;
      if (obs4[i].L != el[i] || obs4[i].H != eh[i] || obs4[i].last != (i == 1)) begin
        failures++;
        $display("FAIL basic_pair%0d got (%0d,%0d,%0b) exp (%0d,%0d,%0b)", i,
                 obs4[i].L, obs4[i].H, obs4[i].last, el[i], eh[i], i == 1);
      end
    end
    if (obs4.size() == 2 && acc4.size() == 4) begin
      checks++; if (obs4[0].cyc != acc4[2] + 1) begin failures++; $display("FAIL basic_lat0 got %0d exp %0d", obs4[0].cyc, acc4[2] + 1); end
      checks++; if (obs4[1].cyc != acc4[3] + 1) begin failures++; $display("FAIL basic_lat1 got %0d exp %0d", obs4[1].cyc, acc4[3] + 1); end
    end
    obs4.delete(); exp4.delete();
  endtask

  task automatic test_constant();
    bit ok;
    rdy_pct16 = 100;
    px.delete();
    for (int i = 0; i < 16; i++) px.push_back(100);
    push_line(1'b1, 1'b0);
    wait_drain(1'b1, ok);
    checks++; if (!ok || obs16.size() != 8) begin failures++; $display("FAIL const_count got %0d exp 8", obs16.size()); end
    for (int i = 0; i < 8 && i < obs16.size(); i++) begin
      checks++;
      if (obs16[i].L != 100 || obs16[i].H != 0 || obs16[i].last != (i == 7)) begin
        failures++;
        $display("FAIL const_pair%0d got (%0d,%0d,%0b) exp (100,0,%0b)", i,
                 obs16[i].L, obs16[i].H, obs16[i].last, i == 7);
      end
    end
    obs16.delete(); exp16.delete();
  endtask

  task automatic test_extremes();
    bit ok;
    rdy_pct16 = 100;
    px.delete();
    for (int i = 0; i < 16; i++) px.push_back((i % 2) ? 255 : 0);
    push_line(1'b1, 1'b0);
    wait_drain(1'b1, ok);
    checks++; if (!ok || obs16.size() != exp16.size()) begin failures++; $display("FAIL ext_count got %0d exp %0d", obs16.size(), exp16.size()); end
    for (int i = 0; i < exp16.size() && i < obs16.size(); i++) begin
      checks++;
      if (obs16[i].L != exp16[i].L || obs16[i].H != exp16[i].H || obs16[i].last != exp16[i].last) begin
        failures++;
        $display("FAIL ext_pair%0d got (%0d,%0d,%0b) exp (%0d,%0d,%0b)", i, obs16[i].L, obs16[i].H,
                 obs16[i].last, exp16[i].L, exp16[i].H, exp16[i].last);
      end
    end
    obs16.delete(); exp16.delete();
  endtask

  task automatic test_random_stall();
    bit ok;
    rdy_pct16 = 50;
    viol16    = 0;
    for (int l = 0; l < 3; l++) begin
      px.delete();
      for (int i = 0; i < 16; i++) px.push_back(int'($urandom_range(255)));
      push_line(1'b1, 1'b0);
    end
    wait_drain(1'b1, ok);
    checks++; if (!ok || obs16.size() != exp16.size()) begin failures++; $display("FAIL rnd_count got %0d exp %0d", obs16.size(), exp16.size()); end
    for (int i = 0; i < exp16.size() && i < obs16.size(); i++) begin
      checks++;
      if (obs16[i].L != exp16[i].L || obs16[i].H != exp16[i].H || obs16[i].last != exp16[i].last) begin
        failures++;
        $display("FAIL rnd_pair%0d got (%0d,%0d,%0b) exp (%0d,%0d,%0b)", i, obs16[i].L, obs16[i].H,
                 obs16[i].last, exp16[i].L, exp16[i].H, exp16[i].last);
      end
    end
    checks++; if (viol16 != 0) begin failures++; $display("FAIL rnd_in_ready got %0d unstalled drops exp 0", viol16); end
    rdy_pct16 = 100;
    obs16.delete(); exp16.delete();
  endtask

  task automatic test_back_to_back();
    bit ok;
    rdy_pct16 = 100;
    viol16    = 0;
    acc16.delete();
    for (int l = 0; l < 2; l++) begin
      px.delete();
      for (int i = 0; i < 16; i++) px.push_back(int'($urandom_range(255)));
      push_line(1'b1, 1'b0);
    end
    wait_drain(1'b1, ok);
    checks++; if (!ok || obs16.size() != 16) begin failures++; $display("FAIL b2b_count got %0d exp 16", obs16.size()); end
    for (int i = 0; i < exp16.size() && i < obs16.size(); i++) begin
      checks++;
      if (obs16[i].L != exp16[i].L || obs16[i].H != exp16[i].H || obs16[i].last != exp16[i].last) begin
        failures++;
        $display("FAIL b2b_pair%0d got (%0d,%0d,%0b) exp (%0d,%0d,%0b)", i, obs16[i].L, obs16[i].H,
                 obs16[i].last, exp16[i].L, exp16[i].H, exp16[i].last);
      end
    end
    if (acc16.size() == 32 && obs16.size() == 16) begin
      checks++; if (acc16[31] - acc16[0] != 31) begin failures++; $display("FAIL b2b_rate got %0d cycles exp 31", acc16[31] - acc16[0]); end
      checks++; if (obs16[7].cyc - obs16[6].cyc != 1) begin failures++; $display("FAIL b2b_tail got gap %0d exp 1", obs16[7].cyc - obs16[6].cyc); end
    end
    checks++; if (viol16 != 0) begin failures++; $display("FAIL b2b_in_ready got %0d drops exp 0", viol16); end
    obs16.delete(); exp16.delete();
  endtask

  task automatic test_mid_reset();
    bit ok;
    rdy_pct4 = 100;
    px = '{22, 44, 50, 70};
    push_line(1'b0, 1'b0);
    inq4.push_back(22); bypq4.push_back(1'b0);
    inq4.push_back(44); bypq4.push_back(1'b0);
    wait_drain(1'b0, ok);
    checks++; if (!ok || obs4.size() != 2) begin failures++; $display("FAIL mrst_pre_count got %0d exp 2", obs4.size()); end
    obs4.delete(); exp4.delete();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #2;
    checks++;
    if (bif4.out_valid !== 1'b0 || bif4.out_L !== 10'sd0 || bif4.out_H !== 10'sd0 || bif4.out_last !== 1'b0) begin
      failures++;
      $display("FAIL mrst_outputs got (%b,%0d,%0d,%b) exp (0,0,0,0)", bif4.out_valid, bif4.out_L, bif4.out_H, bif4.out_last);
    end
    rst_n = 1'b1;
    px = '{22, 44, 50, 70};
    push_line(1'b0, 1'b0);
    wait_drain(1'b0, ok);
    checks++; if (!ok || obs4.size() != 2) begin failures++; $display("FAIL mrst_count got %0d exp 2", obs4.size()); end
    if (obs4.size() == 2) begin
      checks++; if (obs4[0].L != 26 || obs4[0].H != 8 || obs4[0].last != 1'b0) begin failures++; $display("FAIL mrst_pair0 got (%0d,%0d,%0b) exp (26,8,0)", obs4[0].L, obs4[0].H, obs4[0].last); end
      checks++; if (obs4[1].L != 57 || obs4[1].H != 20 || obs4[1].last != 1'b1) begin failures++; $display("FAIL mrst_pair1 got (%0d,%0d,%0b) exp (57,20,1)", obs4[1].L, obs4[1].H, obs4[1].last); end
    end
    obs4.delete(); exp4.delete();
  endtask

`ifdef LIFT53_BYPASS_EN
  task automatic test_bypass();
    bit ok;
    int el[4] = '{22, 50, 26, 57};
    int eh[4] = '{44, 70, 8, 20};
    rdy_pct4 = 100;
    px = '{22, 44, 50, 70};
    push_line(1'b0, 1'b1);
    push_line(1'b0, 1'b0);
    wait_drain(1'b0, ok);
    checks++; if (!ok || obs4.size() != 4) begin failures++; $display("FAIL byp_count got %0d exp 4", obs4.size()); end
    for (int i = 0; i < 4 && i < obs4.size(); i++) begin
      checks++;
      if (obs4[i].L != el[i] || obs4[i].H != eh[i] || obs4[i].last != (i % 2 == 1)) begin
        failures++;
        $display("FAIL byp_pair%0d got (%0d,%0d,%0b) exp (%0d,%0d,%0b)", i,
                 obs4[i].L, obs4[i].H, obs4[i].last, el[i], eh[i], i % 2 == 1);
      end
    end
    obs4.delete(); exp4.delete();
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_basic();
    test_constant();
    test_extremes();
    test_random_stall();
    test_back_to_back();
    test_mid_reset();
`ifdef LIFT53_BYPASS_EN
    test_bypass();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
